// File: rtl/color_shift_sequencer_pkg.sv
// color_shift_sequencer_pkg: shared state/op encodings and default widths for the colour-shift sequencer.
package color_shift_sequencer_pkg;
  localparam int STEP_W_DEF   = 5;
  localparam int RATE_W_DEF   = 8;
  localparam int MAX_STEP_DEF = 31;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_BLANK, S_SETUP, S_PULSE, S_HOLD} state_e;
  typedef enum logic {OP_STEP, OP_CLEAR} op_e;
endpackage

// File: rtl/color_shift_sequencer_frame_rate_divider.sv
// frame_rate_divider: registered vblank rising-edge detect and frames-per-step counter producing a one-cycle step_tick.
module frame_rate_divider #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  output logic              step_tick
);
  logic              vblank_q, vb_rise_q;
  logic [RATE_W-1:0] cnt_q, cnt_d, rate_eff;
  logic [RATE_W:0]   cnt_inc;
  always_comb begin
    rate_eff  = (rate == '0) ? RATE_W'(1) : rate;
    cnt_inc   = {1'b0, cnt_q} + (RATE_W+1)'(1);
    step_tick = enable & vb_rise_q & (cnt_inc >= {1'b0, rate_eff});
    cnt_d     = !(enable & vb_rise_q) ? cnt_q : step_tick ? '0 : cnt_inc[RATE_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q  <= 1'b0;
      vb_rise_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vblank_q  <= vblank;
      vb_rise_q <= vblank & ~vblank_q;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: rtl/color_shift_sequencer.sv
// color_shift_sequencer: generates vblank-confined shft/clear strobes for the colour-shift stage.
// Define SHIFT_AUTO_WRAP_EN to turn a step from MAX_STEP into a clear op.
module color_shift_sequencer
  import color_shift_sequencer_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int RATE_W   = RATE_W_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic              step_req,
  input  logic              clear_req,
  output logic              shft_out,
  output logic              shft_clr,
  output logic [STEP_W-1:0] step_idx,
  output logic              busy
);
  state_e            state_q;
  op_e               op_q, op_sel;
  logic              clr_pend_q, clr_pend_d, step_pend_q, step_pend_d;
  logic              shft_out_q, shft_clr_q, step_tick, svc;
  logic [STEP_W-1:0] idx_q;
  frame_rate_divider #(.RATE_W(RATE_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .vblank   (vblank),
    .enable   (enable),
    .rate     (rate),
    .step_tick(step_tick)
  );
  // Servicing either op consumes any pending step, so a clear always swallows a queued step.
  always_comb begin
    svc = (state_q == S_WAIT_BLANK) & vblank;
`ifdef SHIFT_AUTO_WRAP_EN
    op_sel = (clr_pend_q | (idx_q == STEP_W'(MAX_STEP))) ? OP_CLEAR : OP_STEP;
`else
    op_sel = clr_pend_q ? OP_CLEAR : OP_STEP;
`endif
    clr_pend_d  = clear_req | (clr_pend_q & ~svc);
    step_pend_d = step_req | step_tick | (step_pend_q & ~svc);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_STEP;
      clr_pend_q  <= 1'b1;
      step_pend_q <= 1'b0;
      shft_out_q  <= 1'b0;
      shft_clr_q  <= 1'b0;
      idx_q       <= '0;
    end else begin
      clr_pend_q  <= clr_pend_d;
      step_pend_q <= step_pend_d;
      unique case (state_q)
        S_IDLE: if (clr_pend_q | step_pend_q) state_q <= S_WAIT_BLANK;
        S_WAIT_BLANK: if (vblank) begin
          op_q       <= op_sel;
          shft_clr_q <= (op_sel == OP_CLEAR);
          state_q    <= S_SETUP;
        end
        S_SETUP: begin
          shft_out_q <= 1'b1;
          state_q    <= S_PULSE;
        end
        S_PULSE: begin
          shft_out_q <= 1'b0;
          idx_q      <= (op_q == OP_CLEAR) ? '0 : idx_q + STEP_W'(1);
          state_q    <= S_HOLD;
        end
        S_HOLD: begin
          shft_clr_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign shft_out = shft_out_q;
  assign shft_clr = shft_clr_q;
  assign step_idx = idx_q;
  assign busy     = (state_q != S_IDLE) | clr_pend_q | step_pend_q;
endmodule

// File: doc/color_shift_sequencer.md
Name: color_shift_sequencer

Overview:
- Controller for the colour-shift datapath. It generates the slow `shft` strobe and the `reset` qualifier that the colour-shift stage samples on each `shft` rising edge.
- Advances the shift step automatically every N frames, or on a user step request. Clears the step on request or at power-up.
- All strobes are confined to vertical blanking, so colours never change mid-frame.
- Sits between the frame-timing generator and the colour-shift stage, on the pixel clock.

Parameters:
- STEP_W, 5, width of the mirrored step index; must match the colour-shift stage's counter.
- RATE_W, 8, width of the frames-per-step rate input and the frame counter.
- MAX_STEP, 31, last step index before wrap.

Ports:
- clk  in  1  pixel clock
- reset  in  1  sync reset
- vblank  in  1  vertical blanking, level, high during blank
- enable  in  1  auto-advance enable
- rate  in  RATE_W  frames per auto step; 0 treated as 1
- step_req  in  1  one-cycle pulse, request one step
- clear_req  in  1  one-cycle pulse, request clear to step 0
- shft_out  out  1  strobe to colour-shift stage
- shft_clr  out  1  clear qualifier to colour-shift stage
- step_idx  out  STEP_W  mirror of the downstream step index
- busy  out  1  a strobe sequence is pending or in progress

Behaviour:
- Reset is synchronous and active-high.
- On reset:
  - shft_out=0, shft_clr=0, step_idx=0, busy=1.
  - Frame counter = 0.
  - clr_pend=1, so an init clear always runs first; this clears the downstream index, which our reset does not reach.
  - step_pend=0, vblank_q=0, state=IDLE.
- Frame edge: vb_rise = vblank & ~vblank_q, registered.
- Auto step, when enable=1:
  - On each vb_rise the frame counter increments.
  - When counter+1 >= max(rate,1), the counter goes to 0 and step_pend is set.
  - enable=0 holds the counter at its value.
- Request latches:
  - step_req sets step_pend; clear_req sets clr_pend.
  - Multiple step requests before service collapse to one step.
  - clr_pend has priority: when a clear is serviced, step_pend is also cleared.
- FSM states: IDLE, WAIT_BLANK, SETUP, PULSE, HOLD.
  - IDLE: if clr_pend or step_pend, go to WAIT_BLANK.
  - WAIT_BLANK: if vblank=1, latch op = clear if clr_pend else step, clear that pend flag, go to SETUP.
  - SETUP: shft_clr = (op==clear), shft_out=0.
  - PULSE: shft_out=1, shft_clr held.
  - HOLD: shft_out=0, shft_clr held. Update step_idx (clear → 0; step → step_idx+1, modulo 2^STEP_W). Go to IDLE; the next cycle drops shft_clr.
  - shft_clr is therefore stable one cycle before and one cycle after the shft_out rising edge.
- Latency:
  - With vblank already high, a request pulse at cycle t gives shft_out high at t+4.
  - step_idx updates at t+5.
- Mid-sequence rules:
  - A sequence that has left WAIT_BLANK always completes, even if vblank falls.
  - Requests arriving during a sequence are latched and serviced afterwards.
- Simultaneous step_req and clear_req: clear wins and the step is dropped.
- Auto-step expiring in the same cycle as step_req: one step total.
- busy = (state != IDLE) | clr_pend | step_pend.
- Reset mid-sequence: outputs drop to 0 at the reset edge, then the init clear re-runs.

Optional Feature:
- Macro: SHIFT_AUTO_WRAP_EN.
- Defined: when a step op is latched with step_idx == MAX_STEP, it is converted into a clear op. The downstream index returns to 0 via the clear qualifier instead of overflowing.
- Undefined: steps past MAX_STEP wrap naturally modulo 2^STEP_W.

Decomposition:
- Shared package holds:
  - state encoding constants.
  - op encoding (OP_STEP, OP_CLEAR).
  - default STEP_W / RATE_W.
- One sub-module: frame_rate_divider, containing vblank edge detect, frame counter and rate compare; outputs a one-cycle step_tick.

Test Plan:
- Reset with vblank=1, no requests → init clear:
  - shft_clr high cycles 1-3 after reset release.
  - shft_out high cycle 2 only.
  - step_idx=0, busy falls at cycle 4.
- enable=1, rate=3, 9 vblank pulses → exactly 3 shft_out pulses, each inside vblank; step_idx 0→3.
- rate=0, enable=1, 4 frames → 4 steps (rate 0 behaves as rate 1).
- step_req during active video (vblank=0) → no shft_out until vblank rises; then one pulse, step_idx+1.
- step_req and clear_req in the same cycle, step_idx=7 → one clear sequence, no step; step_idx=0.
- step_idx=31, step_req:
  - With SHIFT_AUTO_WRAP_EN: shft_clr=1 around the pulse, idx=0.
  - Without it: shft_clr=0, idx=0 via wrap.
  - Reset asserted during PULSE: shft_out=0 next cycle, and the init clear sequence follows.
